btn_debounce: RTL and testbench
===============================

Name: btn_debounce

Overview:
- Upstream conditioning stage for the iCEstick LED/button state machine.
- Takes the four raw, asynchronous, active-low push-button inputs and synchronises each one into clk.
- Debounces each channel with a per-channel stability counter.
- Outputs clean active-low levels plus one-cycle press/release strobes; the LED FSM consumes these in place of the raw pins.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 120000, consecutive disagreeing cycles required before the debounced level flips (10 ms at 12 MHz); legal minimum 2.
- CNT_WIDTH, 17, counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to clk.
- btn_level  output  N_BTN  debounced level, active-low, registered.
- btn_press  output  N_BTN  one-cycle strobe on debounced 1->0 transition, registered.
- btn_release  output  N_BTN  one-cycle strobe on debounced 0->1 transition, registered.

Behaviour:
- Reset (rst=1 at a rising edge):
  - sync stage 1 and sync stage 2 = all ones (released).
  - btn_level = all ones.
  - btn_press = 0, btn_release = 0.
  - All counters = 0.
  - Reset asserted mid-count discards the count; no strobe is produced for that edge or while rst=1.
- Synchroniser: two flops per channel, s1 <= btn_in, s2 <= s1. Only s2 feeds the debounce logic.
- Per-channel debounce, evaluated every edge when rst=0:
  - s2 == btn_level:
    - cnt <= 0.
    - Strobes for that channel = 0.
  - s2 != btn_level and cnt < DEBOUNCE_CYCLES-1:
    - cnt <= cnt+1.
    - Strobes = 0.
  - s2 != btn_level and cnt == DEBOUNCE_CYCLES-1:
    - btn_level <= s2.
    - cnt <= 0.
    - If s2 = 0, btn_press <= 1; if s2 = 1, btn_release <= 1.
    - These strobes are high in the same cycle the new btn_level first appears.
- Strobes are exactly one cycle wide; they deassert on the next edge because level and s2 then agree.
- Latency:
  - A clean input change first sampled into s1 at edge E0 produces the btn_level change and strobe at edge E(DEBOUNCE_CYCLES+1), i.e. DEBOUNCE_CYCLES+2 sampling edges including E0.
- Bounce: any single cycle where s2 returns to btn_level clears cnt. The full DEBOUNCE_CYCLES run restarts; partial counts never accumulate.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous strobes in the same cycle.
- Button held pressed through reset release:
  - btn_level starts at 1.
  - A btn_press strobe follows DEBOUNCE_CYCLES+2 edges later. This is intended; the downstream FSM then sees that press.
- press and release are mutually exclusive per channel in any cycle.
- Counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.
- Elaboration-time check: DEBOUNCE_CYCLES >= 2 and CNT_WIDTH sufficient. Simulation $error otherwise.

Test Plan (DEBOUNCE_CYCLES=4, N_BTN=4):
- Reset: rst=1 for 2 cycles with btn_in=4'b0000 -> btn_level=4'b1111, press/release=0 throughout. After rst=0 with btn_in held at 4'b0000 -> btn_press=4'b1111 for exactly one cycle at edge 6 after deassert, btn_level=4'b0000 from then on.
- Clean press on channel 0: btn_in 1111->1110 sampled at E0 -> btn_level[0]=0 and btn_press=4'b0001 at E5 only. Channels 1-3 stay 1 with no strobes.
- Bounce rejection on channel 1: btn_in[1] toggles 0,1,0,1,0 at one-cycle intervals, then holds 0 -> no strobe during toggling. btn_press[1] fires once, 6 edges after the final 1->0.
- Short glitch: btn_in[2]=0 for 3 cycles then back to 1 -> btn_level unchanged, no strobes, cnt returns to 0.
- Release and simultaneity: channels 0 and 3 pressed and settled, then both released on the same cycle -> btn_release=4'b1001 for one cycle, btn_level=4'b1111.
- Reset mid-count: btn_in[0]=0 for 4 cycles, then rst=1 for 1 cycle with btn_in[0] still 0 -> no strobe during the pre-reset count. Count restarts from 0 after reset and btn_press[0] fires once, 6 edges after rst deasserts.

Source files
------------

// File: rtl/btn_debounce_if.sv
// Button bundle between the raw pins and the conditioned outputs.
// master drives the raw pins and observes the outputs; slave is the debouncer.
interface btn_debounce_if #(
   parameter int N_BTN = 4
);
   logic [N_BTN-1:0] btn_in;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;

   modport master (output btn_in, input btn_level, input btn_press, input btn_release);
   modport slave  (input btn_in, output btn_level, output btn_press, output btn_release);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop sync plus per-channel stability counter; active-low level and one-cycle strobes.
// Latency DEBOUNCE_CYCLES+2 sampling edges from pin change to level/strobe; no backpressure.
module btn_debounce #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int CNT_WIDTH       = 17
) (
   input  logic          clk,
   input  logic          rst,
   btn_debounce_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
   end
   if ($clog2(DEBOUNCE_CYCLES) > CNT_WIDTH) begin : g_bad_width
      $error("btn_debounce: CNT_WIDTH too small for DEBOUNCE_CYCLES");
   end

   logic [N_BTN-1:0]     sync1_q;
   logic [N_BTN-1:0]     sync2_q;
   logic [N_BTN-1:0]     level_q;
   logic [N_BTN-1:0]     press_q;
   logic [N_BTN-1:0]     rel_q;
   logic [CNT_WIDTH-1:0] cnt_q [N_BTN];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         level_q <= '1;
         press_q <= '0;
         rel_q   <= '0;
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q <= bus.btn_in;
         sync2_q <= sync1_q;
         for (int i = 0; i < N_BTN; i++) begin
            press_q[i] <= 1'b0;
            rel_q[i]   <= 1'b0;
            // Any cycle agreeing with the current level restarts the full run.
            if (sync2_q[i] == level_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] != CNT_MAX) begin
               cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end else begin
               level_q[i] <= sync2_q[i];
               cnt_q[i]   <= '0;
               press_q[i] <= ~sync2_q[i];
               rel_q[i]   <= sync2_q[i];
            end
         end
      end
   end

   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = rel_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench: stimulus pushes hand-computed strobe events, a negedge monitor pops and checks them.
module tb_btn_debounce;

   localparam int LAT = 6;  // DEBOUNCE_CYCLES(4)+2 edges from drive to strobe

   typedef struct {
      int         cyc;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] level;
   } exp_t;

   logic clk;
   logic rst;
   logic mon_en;
   int   cyc;
   int   errors;
   int   checks;
   exp_t sb [$];

   btn_debounce_if #(.N_BTN(4)) bus ();

   btn_debounce #(
      .N_BTN          (4),
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH      (3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_ev(input int dly, input logic [3:0] p, input logic [3:0] r,
                            input logic [3:0] l);
      exp_t e;
      e.cyc   = cyc + dly;
      e.press = p;
      e.rel   = r;
      e.level = l;
      sb.push_back(e);
   endtask

   // Monitor: any strobe must match the oldest outstanding expected event.
   always @(negedge clk) begin
      if (mon_en && ((bus.btn_press | bus.btn_release) !== 4'b0000)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: press=%b release=%b at cycle %0d, none expected",
                     bus.btn_press, bus.btn_release, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("press", int'(bus.btn_press), int'(e.press));
            chk("release", int'(bus.btn_release), int'(e.rel));
            chk("level_at_strobe", int'(bus.btn_level), int'(e.level));
         end
      end
   end

   initial begin
      clk        = 1'b0;
      cyc        = 0;
      errors     = 0;
      checks     = 0;
      mon_en     = 1'b0;
      rst        = 1'b1;
      bus.btn_in = 4'b0000;

      // Reset with all buttons held pressed
      tick(1);
      mon_en = 1'b1;
      chk("reset_level_e1", int'(bus.btn_level), 4'b1111);
      tick(1);
      chk("reset_level_e2", int'(bus.btn_level), 4'b1111);
      chk("reset_press", int'(bus.btn_press), 0);
      chk("reset_release", int'(bus.btn_release), 0);
      rst = 1'b0;
      expect_ev(LAT, 4'b1111, 4'b0000, 4'b0000);
      tick(10);
      chk("held_level", int'(bus.btn_level), 4'b0000);

      // Release everything to get back to idle
      bus.btn_in = 4'b1111;
      expect_ev(LAT, 4'b0000, 4'b1111, 4'b1111);
      tick(10);

      // Clean press on channel 0
      bus.btn_in = 4'b1110;
      expect_ev(LAT, 4'b0001, 4'b0000, 4'b1110);
      tick(10);
      chk("ch0_level", int'(bus.btn_level), 4'b1110);

      // Bounce on channel 1: 0,1,0,1 then hold 0
      bus.btn_in = 4'b1100; tick(1);
      bus.btn_in = 4'b1110; tick(1);
      bus.btn_in = 4'b1100; tick(1);
      bus.btn_in = 4'b1110; tick(1);
      bus.btn_in = 4'b1100;
      expect_ev(LAT, 4'b0010, 4'b0000, 4'b1100);
      tick(12);
      chk("bounce_level", int'(bus.btn_level), 4'b1100);

      // Two 3-cycle glitches on channel 2 split by one high cycle: counts must not add up
      bus.btn_in = 4'b1000; tick(3);
      bus.btn_in = 4'b1100; tick(1);
      bus.btn_in = 4'b1000; tick(3);
      bus.btn_in = 4'b1100; tick(8);
      chk("glitch_level", int'(bus.btn_level), 4'b1100);

      // Same-cycle press of ch3 and release of ch1
      bus.btn_in = 4'b0110;
      expect_ev(LAT, 4'b1000, 4'b0010, 4'b0110);
      tick(10);

      // Simultaneous release of ch0 and ch3
      bus.btn_in = 4'b1111;
      expect_ev(LAT, 4'b0000, 4'b1001, 4'b1111);
      tick(10);
      chk("release_level", int'(bus.btn_level), 4'b1111);

      // Reset one edge before the count would complete
      bus.btn_in = 4'b1110;
      tick(4);
      rst = 1'b1;
      tick(1);
      chk("midreset_level", int'(bus.btn_level), 4'b1111);
      rst = 1'b0;
      expect_ev(LAT, 4'b0001, 4'b0000, 4'b1110);
      tick(12);
      chk("final_level", int'(bus.btn_level), 4'b1110);

      chk("pending_events", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
